// File: rtl/instr_pkg.sv
// Shared constants and enums for the ADDI/BNE instruction encoder.
package instr_pkg;

  localparam logic       OP_ADDI    = 1'b0;
  localparam logic       OP_BNE     = 1'b1;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_OVF   = 2'd3
  } err_code_e;

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: builds the 32-bit ADDI/BNE word and flags immediates
// that cannot be represented exactly.
module imm_pack
  import instr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  op_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  output logic [31:0]           word_c_o,
  output logic                  range_ok_c_o,
  output logic                  align_ok_c_o
);

  logic [DATA_WIDTH-1:0] sx12;
  logic [DATA_WIDTH-1:0] sx13;

  // An immediate fits iff sign-extending its low field reproduces it.
  always_comb begin
    sx12 = {{(DATA_WIDTH-12){imm_i[11]}}, imm_i[11:0]};
    sx13 = {{(DATA_WIDTH-13){imm_i[12]}}, imm_i[12:0]};
    range_ok_c_o = (op_i == OP_BNE) ? (imm_i == sx13) : (imm_i == sx12);
    align_ok_c_o = !((op_i == OP_BNE) && imm_i[0]);
    if (op_i == OP_BNE) begin
      word_c_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BNE,
                  imm_i[4:1], imm_i[11], OPC_BRANCH};
    end else begin
      word_c_o = {imm_i[11:0], rs1_i, F3_ADDI, rd_i, OPC_OP_IMM};
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams ADDI/BNE field beats into encoded words written to instruction
// memory at consecutive word addresses, with range/alignment/overflow errors.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int unsigned MAX_INSTR  = 256,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_last,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int unsigned CNT_W = $clog2(MAX_INSTR) + 1;

  state_e                state_q, state_d;
  err_code_e             code_q, code_d;
  logic [DATA_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  fin_q, fin_d;
  logic                  ovf_q, ovf_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic [31:0] word_c;
  logic        range_ok_c;
  logic        align_ok_c;
  logic        acc_c;

  imm_pack #(.DATA_WIDTH(DATA_WIDTH)) u_imm_pack (
    .op_i         (in_op),
    .rd_i         (in_rd),
    .rs1_i        (in_rs1),
    .rs2_i        (in_rs2),
    .imm_i        (in_imm),
    .word_c_o     (word_c),
    .range_ok_c_o (range_ok_c),
    .align_ok_c_o (align_ok_c)
  );

  assign acc_c = in_valid && rdy_q;

  // fin_q/ovf_q mark a write cycle that must end the program afterwards.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    fin_d     = 1'b0;
    ovf_d     = 1'b0;
    rdy_d     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d = ST_RUN;
          ptr_d   = base_addr;
          cnt_d   = '0;
          code_d  = ERR_NONE;
          rdy_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (fin_q) begin
          state_d = ST_IDLE;
        end else if (ovf_q) begin
          state_d = ST_ERR;
          code_d  = ERR_OVF;
        end else begin
          rdy_d = 1'b1;
          if (acc_c) begin
            if (!range_ok_c) begin
              state_d = ST_ERR;
              code_d  = ERR_RANGE;
              rdy_d   = 1'b0;
            end else if (!align_ok_c) begin
              state_d = ST_ERR;
              code_d  = ERR_ALIGN;
              rdy_d   = 1'b0;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = DATA_WIDTH'(word_c);
              ptr_d     = ptr_q + DATA_WIDTH'(4);
              cnt_d     = cnt_q + CNT_W'(1);
              if (in_last) begin
                done_d = 1'b1;
                fin_d  = 1'b1;
                rdy_d  = 1'b0;
              end else if (cnt_q == CNT_W'(MAX_INSTR - 1)) begin
                ovf_d = 1'b1;
                rdy_d = 1'b0;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      code_q    <= ERR_NONE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      fin_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      fin_q     <= fin_d;
      ovf_q     <= ovf_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign in_ready = rdy_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a per-cycle behavioural model checked at
// every falling edge plus literal checks on hand-computed words.
module tb_instr_encoder;

  localparam int MAXI = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_ERR = 2;
  localparam int P_NONE = 0, P_LAST = 1, P_OVF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_op = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;
  logic        busy, done, err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_errs = 0;
  int n_wr = 0;

  instr_encoder #(.MAX_INSTR(MAXI), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction word built from field positions with shifts and masks.
  function automatic logic [31:0] enc(input logic op, input logic [31:0] rd,
                                      input logic [31:0] rs1, input logic [31:0] rs2,
                                      input logic [31:0] imm);
    if (!op)
      return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
    return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
           (rs2 << 20) | (rs1 << 15) | (32'h1 << 12) |
           (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
  endfunction

  int          m_mode, m_cnt, m_code, m_pend;
  logic [31:0] m_ptr, m_addr, m_data;
  bit          m_wr, m_done, m_rst;

  task automatic m_reset();
    m_mode = M_IDLE; m_cnt = 0; m_code = 0; m_pend = P_NONE;
    m_ptr = '0; m_addr = '0; m_data = '0; m_wr = 0; m_done = 0; m_rst = 1;
  endtask

  task automatic m_step();
    bit rdy;
    int s;
    bit fits;
    rdy = (m_mode == M_RUN) && (m_pend == P_NONE);
    m_rst = 0; m_wr = 0; m_done = 0;
    if (m_mode != M_RUN) begin
      if (start) begin
        m_mode = M_RUN; m_ptr = base_addr; m_cnt = 0; m_code = 0; m_pend = P_NONE;
      end
    end else if (m_pend == P_LAST) begin
      m_mode = M_IDLE; m_pend = P_NONE;
    end else if (m_pend == P_OVF) begin
      m_mode = M_ERR; m_code = 3; m_pend = P_NONE;
    end else if (in_valid && rdy) begin
      s = $signed(in_imm);
      fits = in_op ? (s >= -4096 && s <= 4095) : (s >= -2048 && s <= 2047);
      if (!fits) begin
        m_mode = M_ERR; m_code = 1;
      end else if (in_op && (s % 2 != 0)) begin
        m_mode = M_ERR; m_code = 2;
      end else begin
        m_wr = 1; m_addr = m_ptr;
        m_data = enc(in_op, 32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm);
        m_ptr = m_ptr + 32'd4;
        if (in_last) begin
          m_done = 1; m_pend = P_LAST;
        end else if (m_cnt == MAXI - 1) begin
          m_pend = P_OVF;
        end
        m_cnt++;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) n_wr++;
      chk("wr_en", 32'(wr_en), 32'(m_wr));
      chk("in_ready", 32'(in_ready), 32'((m_mode == M_RUN) && (m_pend == P_NONE)));
      chk("busy", 32'(busy), 32'(m_mode == M_RUN));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_mode == M_ERR));
      chk("err_code", 32'(err_code), 32'(m_code));
      if (m_wr || m_rst) begin
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
      end
    end
  end

  task automatic do_start(input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents one beat and returns 1 time unit after the edge that took it.
  task automatic beat(input logic op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    bit r;
    int n;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    r = 0; n = 0;
    while (!r && n < 20) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!r) begin
      n_checks++; n_errs++;
      $display("FAIL beat_accept: in_ready stayed %b for 20 cycles, expected 1", in_ready);
    end
  endtask

  int wr_base;

  initial begin
    chk("enc_addi_5", enc(1'b0, 1, 0, 0, 5), 32'h00500093);
    chk("enc_addi_m1", enc(1'b0, 1, 1, 0, -1), 32'hFFF08093);
    chk("enc_bne_m4", enc(1'b1, 0, 1, 0, -4), 32'hFE009EE3);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err_code", 32'(err_code), 0);
    rst_n = 1'b1;

    // Single last ADDI.
    do_start(32'h0);
    beat(1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    chk("t1_wr_en", 32'(wr_en), 1);
    chk("t1_addr", wr_addr, 32'h0);
    chk("t1_data", wr_data, 32'h00500093);
    chk("t1_done", 32'(done), 1);
    @(posedge clk); #1;
    chk("t1_idle_busy", 32'(busy), 0);

    // Back-to-back ADDI then BNE.
    do_start(32'h0);
    beat(1'b0, 5'd1, 5'd1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    chk("t2_addr0", wr_addr, 32'h0);
    chk("t2_data0", wr_data, 32'hFFF08093);
    beat(1'b1, 5'd0, 5'd1, 5'd0, 32'hFFFF_FFFC, 1'b1);
    chk("t2_addr1", wr_addr, 32'h4);
    chk("t2_data1", wr_data, 32'hFE009EE3);
    chk("t2_done", 32'(done), 1);

    // ADDI range limits.
    do_start(32'h0);
    beat(1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
    chk("t3_no_wr", 32'(wr_en), 0);
    chk("t3_err", 32'(err), 1);
    chk("t3_code", 32'(err_code), 1);
    do_start(32'h0);
    beat(1'b0, 5'd2, 5'd3, 5'd0, 32'hFFFF_F800, 1'b1);
    chk("t3_neg2048", 32'(wr_data[31:20]), 32'h800);

    // BNE odd offset, restart, then both faults together.
    do_start(32'h40);
    beat(1'b1, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    chk("t4_no_wr", 32'(wr_en), 0);
    chk("t4_code", 32'(err_code), 2);
    do_start(32'h40);
    chk("t4_restart_err", 32'(err), 0);
    chk("t4_restart_busy", 32'(busy), 1);
    beat(1'b1, 5'd0, 5'd1, 5'd2, 32'd4097, 1'b0);
    chk("t4_both_code", 32'(err_code), 1);

    // Largest representable immediates.
    do_start(32'h0);
    beat(1'b0, 5'd5, 5'd6, 5'd0, 32'd2047, 1'b0);
    chk("t5_addi2047", wr_data, 32'h7FF30293);
    beat(1'b1, 5'd0, 5'd7, 5'd8, 32'hFFFF_F000, 1'b1);
    chk("t5_bne_m4096", wr_data, 32'h80839063);

    // Overflow at MAX_INSTR beats.
    do_start(32'h200);
    wr_base = n_wr;
    for (int i = 0; i < 4; i++) beat(1'b0, 5'(i), 5'd0, 5'd0, 32'(i), 1'b0);
    chk("t6_addr3", wr_addr, 32'h20C);
    chk("t6_ready_low", 32'(in_ready), 0);
    in_valid = 1'b1; in_imm = 32'd9; in_last = 1'b0;
    @(posedge clk); #1;
    chk("t6_code", 32'(err_code), 3);
    chk("t6_err", 32'(err), 1);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t6_writes", 32'(n_wr - wr_base), 4);

    // Stalls, ignored start while running, address wrap.
    do_start(32'hFFFF_FFF8);
    beat(1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    chk("t7_addr0", wr_addr, 32'hFFFF_FFF8);
    start = 1'b1; base_addr = 32'h1000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    beat(1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0);
    chk("t7_addr1", wr_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    beat(1'b0, 5'd3, 5'd0, 5'd0, 32'd3, 1'b1);
    chk("t7_wrap", wr_addr, 32'h0);

    // Reset right after an accepted beat.
    do_start(32'h80);
    beat(1'b0, 5'd1, 5'd0, 5'd0, 32'd7, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t8_wr_en", 32'(wr_en), 0);
    chk("t8_wr_addr", wr_addr, 0);
    chk("t8_wr_data", wr_data, 0);
    chk("t8_busy", 32'(busy), 0);
    chk("t8_ready", 32'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_start(32'h0);
    beat(1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    chk("t8_after_addr", wr_addr, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter MAX_INSTR, default 256: maximum instructions per program; a power of two, at least 2.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: width of the instruction word and address.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse; loads base_addr and begins a program.
REQ-006 base_addr  input  DATA_WIDTH  byte address of the first instruction.
REQ-007 in_valid / in_ready  input / output  1 each  field-beat handshake.
REQ-008 in_op  input  1  instruction select: 0=ADDI, 1=BNE.
REQ-009 in_rd, in_rs1, in_rs2  input  5 each  register indices; in_rd is ignored for BNE, in_rs2 is ignored for ADDI.
REQ-010 in_imm  input  DATA_WIDTH  full-width signed immediate.
REQ-011 in_last  input  1  marks the final beat of the program.
REQ-012 wr_en, wr_addr, wr_data  output  1, DATA_WIDTH, DATA_WIDTH  instruction-memory write port.
REQ-013 busy  output  1  high when state is RUN.
REQ-014 done  output  1  one-cycle pulse when the program completes.
REQ-015 err  output  1  high when state is ERR.
REQ-016 err_code  output  2  error cause: 0=none, 1=imm range, 2=BNE odd offset, 3=overflow.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and ERR.
REQ-018 FSM transitions SHALL be: IDLE/ERR + start -> RUN; RUN + error -> ERR; RUN + last beat written -> IDLE.
REQ-019 start SHALL be ignored in RUN.
REQ-020 On start, the block SHALL set ptr=base_addr, count=0 and err_code=0.
REQ-021 in_ready SHALL be high only in RUN and not in the cycle in which the last beat is being written.
REQ-022 A beat SHALL be accepted when in_valid and in_ready are both high.
REQ-023 Accept-to-write latency SHALL be exactly 1 cycle: wr_en=1, wr_addr=ptr and wr_data=encoded word; ptr then advances by 4 and count by 1.
REQ-024 Back-to-back beats SHALL sustain 1 write per cycle.
REQ-025 The ADDI encoding SHALL be {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
REQ-026 The BNE encoding SHALL be {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}.
REQ-027 Range check: an ADDI beat SHALL require in_imm[31:11] all equal; a BNE beat SHALL require in_imm[31:12] all equal; this is the exact inverse of sign extension.
REQ-028 A BNE beat with in_imm[0]=1 SHALL be rejected with err_code=2.
REQ-029 A beat failing the range check SHALL be rejected with err_code=1; if both conditions fail, err_code SHALL be 1.
REQ-030 A rejected beat SHALL be consumed, SHALL NOT be written, and SHALL move the FSM to ERR.
REQ-031 Accepting a non-last beat when count = MAX_INSTR-1 SHALL write that beat, then set err_code=3 and move to ERR.
REQ-032 A beat with in_last=1 SHALL cause done=1 in the same cycle as its write, followed by IDLE.
REQ-033 err and err_code SHALL hold until the next start.
REQ-034 ptr SHALL wrap modulo 2^DATA_WIDTH without any flag.

Reset
REQ-035 While rst_n=0, the block SHALL hold state=IDLE, ptr=0, count=0, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, busy=0, done=0, err=0 and err_code=0.
REQ-036 Reset asserted mid-program SHALL abort immediately with no further write; a beat pending write is discarded.

Structure
REQ-037 Package instr_pkg SHALL hold the opcode and funct3 constants, the state enum and the err_code enum.
REQ-038 Sub-module imm_pack SHALL be combinational: op, regs and imm in -> 32-bit word plus range_ok and align_ok out.
REQ-039 The FSM, pointer, counter and output register SHALL reside in instr_encoder.

Verification
REQ-040 Bench SHALL cover: start with base_addr=0x0; ADDI rd=1, rs1=0, imm=5, last -> wr_addr=0x0, wr_data=0x00500093, done the same cycle.
REQ-041 Bench SHALL cover: ADDI rd=1, rs1=1, imm=-1 then BNE rs1=1, rs2=0, imm=-4, last, back-to-back -> 0xFFF08093 at 0x0 and 0xFE009EE3 at 0x4 on consecutive cycles.
REQ-042 Bench SHALL cover: ADDI imm=2048 -> no wr_en, err=1, err_code=1; ADDI imm=-2048 accepted -> wr_data[31:20]=0x800.
REQ-043 Bench SHALL cover: BNE imm=3 -> err_code=2 and no write; then start -> err=0 and RUN.
REQ-044 Bench SHALL cover: MAX_INSTR=4, five beats without last -> 4 writes, then err_code=3 and in_ready=0.
REQ-045 Bench SHALL cover: rst_n low in the cycle after accepting a beat -> no wr_en and all outputs 0; in_valid stalls mid-program -> no wr_en gaps are misaddressed.
